// File: rtl/mt_mode_fsm_pkg.sv
// Shared types for the single/multi-thread mode FSM.
// Holds the state encoding, the reset state and the transition function.
package mt_fsm_pkg;

    typedef enum logic {
        ST_SINGLE = 1'b0,
        ST_MULTI  = 1'b1
    } mt_state_t;

    localparam mt_state_t MT_STATE_RESET = ST_SINGLE;

    // The mode simply tracks the request bit one edge later; kept as a
    // function so the decision is stated once per state.
    function automatic mt_state_t mt_next_state(input mt_state_t cur, input logic mt_req);
        mt_state_t nxt;
        nxt = cur;
        case (cur)
            ST_SINGLE: begin
                if (mt_req == 1'b1) begin
                    nxt = ST_MULTI;
                end else begin
                    nxt = ST_SINGLE;
                end
            end
            ST_MULTI: begin
                if (mt_req == 1'b0) begin
                    nxt = ST_SINGLE;
                end else begin
                    nxt = ST_MULTI;
                end
            end
            default: nxt = MT_STATE_RESET;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/mt_mode_fsm_if.sv
// Mode request / mode status bundle between the core control unit and mt_mode_fsm.
// The switch_cnt member exists only when MT_FSM_SWITCH_CNT_EN is defined.
interface mt_mode_fsm_if #(
    parameter int SWITCH_CNT_W = 16
);

    logic MT;
    logic state;
`ifdef MT_FSM_SWITCH_CNT_EN
    logic [SWITCH_CNT_W-1:0] switch_cnt;

    modport master (
        output MT,
        input  state,
        input  switch_cnt
    );

    modport slave (
        input  MT,
        output state,
        output switch_cnt
    );
`else
    modport master (
        output MT,
        input  state
    );

    modport slave (
        input  MT,
        output state
    );
`endif

endinterface

// File: rtl/mt_mode_fsm.sv
// Tracks single-thread vs multi-thread mode of one RV32I core; state follows MT one edge later.
// Optional mode-transition counter enabled by defining MT_FSM_SWITCH_CNT_EN.
module mt_mode_fsm
    import mt_fsm_pkg::*;
#(
    parameter int SWITCH_CNT_W = 16
) (
    input  logic          clock,
    input  logic          async_reset,
    mt_mode_fsm_if.slave  bus
);

    mt_state_t state_q;
    mt_state_t state_d;

    if (SWITCH_CNT_W < 1) begin : g_bad_cnt_w
        $error("mt_mode_fsm: SWITCH_CNT_W must be at least 1");
    end

    // Next-state decode from the current mode and the request bit.
    always_comb begin
        state_d = state_q;
        state_d = mt_next_state(state_q, bus.MT);
    end

    // Mode register; reset forces SINGLE without waiting for a clock.
    always_ff @(posedge clock or negedge async_reset) begin
        if (!async_reset) begin
            state_q <= MT_STATE_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    assign bus.state = state_q;

`ifdef MT_FSM_SWITCH_CNT_EN
    logic [SWITCH_CNT_W-1:0] cnt_q;
    logic [SWITCH_CNT_W-1:0] cnt_d;

    // Count every edge on which the mode actually changes; wraps naturally.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = cnt_q + SWITCH_CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Transition counter register, cleared together with the mode.
    always_ff @(posedge clock or negedge async_reset) begin
        if (!async_reset) begin
            cnt_q <= {SWITCH_CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.switch_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_mt_mode_fsm.sv
// Directed self-checking bench for mt_mode_fsm (counter checks when MT_FSM_SWITCH_CNT_EN is defined).
module tb_mt_mode_fsm;

`ifdef MT_FSM_SWITCH_CNT_EN
    localparam int CNT_W = 2;
`else
    localparam int CNT_W = 16;
`endif

    logic clock;
    logic async_reset;
    int   checks;
    int   failures;

    mt_mode_fsm_if #(.SWITCH_CNT_W(CNT_W)) bus ();

    mt_mode_fsm #(.SWITCH_CNT_W(CNT_W)) dut (
        .clock       (clock),
        .async_reset (async_reset),
        .bus         (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        checks = checks + 1;
        if (obs !== exp_v) begin
            failures = failures + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    logic tv_mt [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
`ifdef MT_FSM_SWITCH_CNT_EN
    logic       cv_mt  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [1:0] cv_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
`endif

    initial begin
        checks      = 0;
        failures    = 0;
        async_reset = 1'b1;
        bus.MT      = 1'b0;
        #1;
        async_reset = 1'b0;
        bus.MT      = 1'bx;
        #1;
        check_eq("rst_async", {15'd0, bus.state}, 16'd0);
`ifdef MT_FSM_SWITCH_CNT_EN
        check_eq("rst_cnt", 16'(bus.switch_cnt), 16'd0);
`endif

        // Edge at 5 ns happens with reset asserted and MT unknown.
        @(negedge clock);
        check_eq("rst_hold_x", {15'd0, bus.state}, 16'd0);
        async_reset = 1'b1;
        bus.MT      = 1'b1;
        #1;
        check_eq("rst_release", {15'd0, bus.state}, 16'd0);

        @(negedge clock);
        check_eq("single_to_multi", {15'd0, bus.state}, 16'd1);
        bus.MT = 1'b0;
        #1;
        check_eq("no_comb_path", {15'd0, bus.state}, 16'd1);

        @(negedge clock);
        check_eq("multi_to_single", {15'd0, bus.state}, 16'd0);
        @(negedge clock);
        check_eq("single_stay", {15'd0, bus.state}, 16'd0);

        bus.MT = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check_eq("multi_stay", {15'd0, bus.state}, 16'd1);
        end

        // Reset asserted between edges must act without a clock.
        #2;
        async_reset = 1'b0;
        #1;
        check_eq("rst_mid", {15'd0, bus.state}, 16'd0);
        @(posedge clock);
        #1;
        check_eq("rst_mid_hold", {15'd0, bus.state}, 16'd0);

        @(negedge clock);
        async_reset = 1'b1;
        bus.MT      = tv_mt[0];
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check_eq("toggle_follow", {15'd0, bus.state}, {15'd0, tv_mt[i]});
            bus.MT = ~tv_mt[i];
            #1;
            check_eq("toggle_hold", {15'd0, bus.state}, {15'd0, tv_mt[i]});
        end

`ifdef MT_FSM_SWITCH_CNT_EN
        // Fresh reset, then five transitions to walk the 2-bit counter through its wrap.
        @(negedge clock);
        async_reset = 1'b0;
        #1;
        check_eq("cnt_rst", 16'(bus.switch_cnt), 16'd0);
        @(negedge clock);
        async_reset = 1'b1;
        bus.MT      = cv_mt[0];
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check_eq("cnt_seq", 16'(bus.switch_cnt), {14'd0, cv_cnt[i]});
            check_eq("cnt_state", {15'd0, bus.state}, {15'd0, cv_mt[i]});
            if (i < 4) begin
                bus.MT = cv_mt[i+1];
            end else begin
                bus.MT = cv_mt[i];
            end
        end
        @(negedge clock);
        check_eq("cnt_hold", 16'(bus.switch_cnt), 16'd1);
        async_reset = 1'b0;
        #1;
        check_eq("cnt_rst_end", 16'(bus.switch_cnt), 16'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
